// File: rtl/register_file_pkg.sv
// Shared CPU datapath constants: register width and count used by the register
// file, datapath and ALU, plus the address-width helper.
package register_file_pkg;
   localparam int RF_WIDTH = 8;
   localparam int RF_DEPTH = 4;

   function automatic int rf_addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/register_file_reg_en.sv
// WIDTH-bit edge-triggered register with enable and asynchronous reset, built
// from a master latch (open while clk low) feeding a slave latch (open while clk high).
module reg_en
   import register_file_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic             master_en;
   logic [WIDTH-1:0] master_d;

   // The master captures enable together with data, so whatever en/d look like
   // at the rising edge is what gets committed; glitches before that are harmless.
   always_latch begin
      if (rst) begin
         master_en <= 1'b0;
         master_d  <= '0;
      end else if (!clk) begin
         master_en <= en;
         master_d  <= d;
      end
   end

   always_latch begin
      if (rst) begin
         q <= '0;
      end else if (clk && master_en) begin
         q <= master_d;
      end
   end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file; register 0 is hardwired to zero and
// reads are purely combinational.
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = rf_addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_a,
   output logic [WIDTH-1:0]  rdata_b
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] wr_sel;

   assign regs[0]   = '0;
   assign wr_sel[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < DEPTH; gi++) begin : g_reg
         assign wr_sel[gi] = we && (waddr == ADDR_W'(gi));

         reg_en #(.WIDTH(WIDTH)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_sel[gi]),
            .d   (wdata),
            .q   (regs[gi])
         );
      end
   endgenerate

   // Addresses beyond DEPTH (non power-of-two sizes) read as zero.
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (int'(raddr_a) < DEPTH) rdata_a = regs[raddr_a];
      if (int'(raddr_b) < DEPTH) rdata_b = regs[raddr_b];
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// run, with expected read data queued at stimulus time and popped on sampling.
module tb_register_file;
   logic       clk;
   logic       rst;
   logic       we;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic [1:0] raddr_a;
   logic [1:0] raddr_b;
   logic [7:0] rdata_a;
   logic [7:0] rdata_b;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mdl [4];
   logic [7:0] e;

   register_file #(.WIDTH(8), .DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      we = 1'b1;
      waddr = a;
      wdata = d;
      if (a != 2'd0) mdl[a] = d;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset;
      raddr_a = 2'd1;
      raddr_b = 2'd2;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL reset_init_a got=%h exp=%h", rdata_a, e); n_bad++; end
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL reset_init_b got=%h exp=%h", rdata_b, e); n_bad++; end
      @(negedge clk);
      rst = 1'b0;
      do_write(2'd1, 8'hFF);
      do_write(2'd2, 8'hFF);
      do_write(2'd3, 8'hFF);
      @(negedge clk);
      raddr_a = 2'd1;
      raddr_b = 2'd2;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL preload_a got=%h exp=%h", rdata_a, e); n_bad++; end
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL preload_b got=%h exp=%h", rdata_b, e); n_bad++; end
      #1;
      rst = 1'b1;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL async_clear_a got=%h exp=%h", rdata_a, e); n_bad++; end
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL async_clear_b got=%h exp=%h", rdata_b, e); n_bad++; end
      raddr_a = 2'd3;
      raddr_b = 2'd3;
      exp_q.push_back(8'h00);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL async_clear_r3 got=%h exp=%h", rdata_a, e); n_bad++; end
      // Writes while reset is held must be dropped.
      we = 1'b1;
      waddr = 2'd1;
      wdata = 8'hAA;
      raddr_a = 2'd1;
      exp_q.push_back(8'h00);
      @(posedge clk);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL reset_write_ignored got=%h exp=%h", rdata_a, e); n_bad++; end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
      waddr = 2'd1;
      wdata = 8'h11;
      mdl[1] = 8'h11;
      exp_q.push_back(8'h11);
      @(posedge clk);
      #1;
      we = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL first_write_after_reset got=%h exp=%h", rdata_a, e); n_bad++; end
   endtask

   task automatic test_basic;
      do_write(2'd1, 8'hA5);
      do_write(2'd2, 8'h3C);
      do_write(2'd3, 8'h0F);
      raddr_a = 2'd1;
      raddr_b = 2'd2;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL basic_a1 got=%h exp=%h", rdata_a, e); n_bad++; end
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL basic_b2 got=%h exp=%h", rdata_b, e); n_bad++; end
      raddr_a = 2'd3;
      raddr_b = 2'd3;
      exp_q.push_back(8'h0F);
      exp_q.push_back(8'h0F);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL basic_a3 got=%h exp=%h", rdata_a, e); n_bad++; end
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL basic_b3 got=%h exp=%h", rdata_b, e); n_bad++; end
   endtask

   task automatic test_reg0;
      do_write(2'd0, 8'hFF);
      raddr_a = 2'd0;
      raddr_b = 2'd0;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL reg0_a got=%h exp=%h", rdata_a, e); n_bad++; end
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL reg0_b got=%h exp=%h", rdata_b, e); n_bad++; end
   endtask

   task automatic test_enable_gating;
      do_write(2'd2, 8'h3C);
      we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         waddr = 2'd2;
         wdata = 8'h99;
         #2;
         waddr = 2'($urandom);
         wdata = 8'($urandom);
         #1;
         waddr = 2'd2;
         wdata = 8'h99;
         @(posedge clk);
      end
      #1;
      raddr_b = 2'd2;
      exp_q.push_back(8'h3C);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL enable_gating got=%h exp=%h", rdata_b, e); n_bad++; end
   endtask

   task automatic test_read_during_write;
      do_write(2'd1, 8'hA5);
      raddr_a = 2'd1;
      we = 1'b1;
      waddr = 2'd1;
      wdata = 8'h5A;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL rdw_clk_high got=%h exp=%h", rdata_a, e); n_bad++; end
      @(negedge clk);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL rdw_clk_low got=%h exp=%h", rdata_a, e); n_bad++; end
      @(posedge clk);
      #1;
      we = 1'b0;
      mdl[1] = 8'h5A;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL rdw_after_edge got=%h exp=%h", rdata_a, e); n_bad++; end
   endtask

   task automatic test_reset_race;
      @(negedge clk);
      we = 1'b1;
      waddr = 2'd3;
      wdata = 8'h77;
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      we = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
      raddr_a = 2'd3;
      raddr_b = 2'd1;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_a !== e) begin $display("FAIL reset_race_r3 got=%h exp=%h", rdata_a, e); n_bad++; end
      e = exp_q.pop_front(); n_cmp++;
      if (rdata_b !== e) begin $display("FAIL reset_race_r1 got=%h exp=%h", rdata_b, e); n_bad++; end
   endtask

   task automatic test_random;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         we = 1'($urandom);
         waddr = 2'($urandom);
         wdata = 8'($urandom);
         raddr_a = 2'($urandom);
         raddr_b = 2'($urandom);
         exp_q.push_back(mdl[raddr_a]);
         exp_q.push_back(mdl[raddr_b]);
         if (we && waddr != 2'd0) mdl[waddr] = wdata;
         #1;
         e = exp_q.pop_front(); n_cmp++;
         if (rdata_a !== e) begin $display("FAIL rand_pre_a it=%0d addr=%0d got=%h exp=%h", i, raddr_a, rdata_a, e); n_bad++; end
         e = exp_q.pop_front(); n_cmp++;
         if (rdata_b !== e) begin $display("FAIL rand_pre_b it=%0d addr=%0d got=%h exp=%h", i, raddr_b, rdata_b, e); n_bad++; end
         exp_q.push_back(mdl[raddr_a]);
         exp_q.push_back(mdl[raddr_b]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front(); n_cmp++;
         if (rdata_a !== e) begin $display("FAIL rand_post_a it=%0d addr=%0d got=%h exp=%h", i, raddr_a, rdata_a, e); n_bad++; end
         e = exp_q.pop_front(); n_cmp++;
         if (rdata_b !== e) begin $display("FAIL rand_post_b it=%0d addr=%0d got=%h exp=%h", i, raddr_b, rdata_b, e); n_bad++; end
         $display("rand it=%0d we=%0d waddr=%0d wdata=%h ra=%0d:%h rb=%0d:%h", i, we, waddr, wdata, raddr_a, rdata_a, raddr_b, rdata_b);
      end
      we = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      we = 1'b0;
      waddr = 2'd0;
      wdata = 8'h00;
      raddr_a = 2'd0;
      raddr_b = 2'd0;
      for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
      test_reset();
      test_basic();
      test_reg0();
      test_enable_gating();
      test_read_during_write();
      test_reset_race();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
